// File: rtl/exu_alu_mc_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle execute unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU opcode constants (also used by the IDU decoder), EXU FSM
// state encoding, and an opcode-class helper.
package exu_alu_mc_pkg;

   localparam logic [3:0] ALU_UND0  = 4'h0;
   localparam logic [3:0] ALU_ADD   = 4'h1;
   localparam logic [3:0] ALU_SUB   = 4'h2;
   localparam logic [3:0] ALU_XOR   = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_AND   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SLL   = 4'h7;
   localparam logic [3:0] ALU_SRA   = 4'h8;
   localparam logic [3:0] ALU_MUL   = 4'h9;
   localparam logic [3:0] ALU_MULHU = 4'hA;
   localparam logic [3:0] ALU_DIVU  = 4'hB;
   localparam logic [3:0] ALU_REMU  = 4'hC;
   localparam logic [3:0] ALU_DIV   = 4'hD;
   localparam logic [3:0] ALU_REM   = 4'hE;
   localparam logic [3:0] ALU_UND1  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } exu_state_e;

   // Multiply/divide class: handled by the iterative engine.
   function automatic logic is_mdu_op(input logic [3:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REM);
   endfunction

endpackage

// File: rtl/exu_muldiv_iter.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide.
// Latency: W cycles from start; 'last' flags the final step, 'result' is valid with it.
// Backpressure: none; the parent FSM owns the handshake, flush aborts at once.
// Ports: clk/rst (sync, active-high), flush, start, op/a/b (sampled on start),
//        special/special_res (combinational div special-case detection on a/b/op),
//        last (final step this cycle), result (value produced by the final step).
module exu_muldiv_iter
   import exu_alu_mc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         special,
   output logic [W-1:0] special_res,
   output logic         last,
   output logic [W-1:0] result
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   logic [CW-1:0]  cnt;
   logic [3:0]     op_q;
   logic [2*W-1:0] prod;
   logic [W-1:0]   mcand;
   logic [W:0]     prem;
   logic [W-1:0]   quo;
   logic [W-1:0]   dvsr;
   logic           neg_q;
   logic           neg_r;

   logic           signed_op;
   logic           is_div;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic           div_zero;
   logic           div_ovf;

   logic [W:0]     add_hi;
   logic [2*W-1:0] prod_nxt;
   logic [W:0]     shifted;
   logic [W:0]     diff;
   logic [W:0]     prem_nxt;
   logic [W-1:0]   quo_nxt;

   // Accept-time decode on the live operands.
   always_comb begin
      signed_op   = (op == ALU_DIV) || (op == ALU_REM);
      is_div      = (op >= ALU_DIVU) && (op <= ALU_REM);
      a_neg       = signed_op && a[W-1];
      b_neg       = signed_op && b[W-1];
      // The most-negative value maps onto itself, which is its correct unsigned magnitude.
      a_mag       = a_neg ? -a : a;
      b_mag       = b_neg ? -b : b;
      div_zero    = (b == '0);
      div_ovf     = signed_op && (a == MIN_VAL) && (b == '1);
      special     = is_div && (div_zero || div_ovf);
      special_res = '0;
      if (div_zero) begin
         special_res = ((op == ALU_DIVU) || (op == ALU_DIV)) ? '1 : a;
      end else if (div_ovf) begin
         special_res = (op == ALU_DIV) ? MIN_VAL : '0;
      end
   end

   // One step of each datapath; both run every cycle, op_q picks the answer.
   always_comb begin
      add_hi   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
      prod_nxt = {add_hi, prod[W-1:1]};
      shifted  = {prem[W-1:0], quo[W-1]};
      diff     = shifted - {1'b0, dvsr};
      if (diff[W]) begin
         prem_nxt = shifted;
         quo_nxt  = {quo[W-2:0], 1'b0};
      end else begin
         prem_nxt = diff;
         quo_nxt  = {quo[W-2:0], 1'b1};
      end
   end

   always_comb begin
      result = '0;
      case (op_q)
         ALU_MUL:   result = prod_nxt[W-1:0];
         ALU_MULHU: result = prod_nxt[2*W-1:W];
         ALU_DIVU:  result = quo_nxt;
         ALU_REMU:  result = prem_nxt[W-1:0];
         ALU_DIV:   result = neg_q ? -quo_nxt : quo_nxt;
         ALU_REM:   result = neg_r ? -prem_nxt[W-1:0] : prem_nxt[W-1:0];
         default:   result = '0;
      endcase
   end

   assign last = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         op_q  <= '0;
         prod  <= '0;
         mcand <= '0;
         prem  <= '0;
         quo   <= '0;
         dvsr  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (flush) begin
         cnt   <= '0;
      end else if (start) begin
         cnt   <= CW'(W);
         op_q  <= op;
         prod  <= {{W{1'b0}}, a};
         mcand <= b;
         prem  <= '0;
         quo   <= a_mag;
         dvsr  <= b_mag;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (cnt != '0) begin
         cnt   <= cnt - CW'(1);
         prod  <= prod_nxt;
         prem  <= prem_nxt;
         quo   <= quo_nxt;
      end
   end

endmodule

// File: rtl/exu_alu_mc.sv
// Multi-cycle EXU: single-cycle ALU plus iterative mul/div behind a valid/ready FSM.
// Latency: 1 cycle for base ops and div special cases, W+1 cycles for mul/div.
// Backpressure: result held in DONE until i_wbu_ready; o_exu_ready only in IDLE.
// Ports: i_clk, i_rst (sync, active-high), i_flush; IDU side i_idu_valid/o_exu_ready,
//        i_idu_aluop, i_idu_rs1_data, i_idu_rs2_data; WBU side o_exu_valid/i_wbu_ready,
//        o_exu_aluout; o_exu_busy while iterating.
module exu_alu_mc
   import exu_alu_mc_pkg::*;
#(
   parameter int W          = 32,
   parameter bit ENABLE_MDU = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_idu_valid,
   output logic         o_exu_ready,
   input  logic [3:0]   i_idu_aluop,
   input  logic [W-1:0] i_idu_rs1_data,
   input  logic [W-1:0] i_idu_rs2_data,
   output logic         o_exu_valid,
   input  logic         i_wbu_ready,
   output logic [W-1:0] o_exu_aluout,
   output logic         o_exu_busy
);

   localparam int SHW = $clog2(W);

   exu_state_e   state;
   exu_state_e   state_nxt;
   logic         accept;
   logic         mdu_sel;
   logic         eng_start;
   logic         eng_special;
   logic [W-1:0] eng_special_res;
   logic         eng_last;
   logic [W-1:0] eng_result;
   logic [W-1:0] alu_res;
   logic [SHW-1:0] shamt;

   // Flush blocks acceptance even when IDU offers an op in IDLE.
   assign accept    = i_idu_valid && o_exu_ready && !i_flush;
   assign mdu_sel   = ENABLE_MDU && is_mdu_op(i_idu_aluop);
   assign eng_start = accept && mdu_sel && !eng_special;
   assign shamt     = i_idu_rs2_data[SHW-1:0];

   exu_muldiv_iter #(.W(W)) u_muldiv (
      .clk         (i_clk),
      .rst         (i_rst),
      .flush       (i_flush),
      .start       (eng_start),
      .op          (i_idu_aluop),
      .a           (i_idu_rs1_data),
      .b           (i_idu_rs2_data),
      .special     (eng_special),
      .special_res (eng_special_res),
      .last        (eng_last),
      .result      (eng_result)
   );

   // Single-cycle result; mul/div opcodes only land here for div special cases.
   always_comb begin
      alu_res = '0;
      case (i_idu_aluop)
         ALU_ADD: alu_res = i_idu_rs1_data + i_idu_rs2_data;
         ALU_SUB: alu_res = i_idu_rs1_data - i_idu_rs2_data;
         ALU_XOR: alu_res = i_idu_rs1_data ^ i_idu_rs2_data;
         ALU_OR:  alu_res = i_idu_rs1_data | i_idu_rs2_data;
         ALU_AND: alu_res = i_idu_rs1_data & i_idu_rs2_data;
         ALU_SRL: alu_res = i_idu_rs1_data >> shamt;
         ALU_SLL: alu_res = i_idu_rs1_data << shamt;
         ALU_SRA: alu_res = $unsigned($signed(i_idu_rs1_data) >>> shamt);
         default: alu_res = (mdu_sel && eng_special) ? eng_special_res : '0;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = eng_start ? ST_CALC : ST_DONE;
         ST_CALC: if (eng_last) state_nxt = ST_DONE;
         ST_DONE: if (i_wbu_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (i_flush) state_nxt = ST_IDLE;
   end

   // Output logic
   always_comb begin
      o_exu_ready = (state == ST_IDLE) && !i_rst;
      o_exu_valid = (state == ST_DONE);
      o_exu_busy  = (state == ST_CALC);
   end

   // Result register; a flushed op never writes, and its stale value is never flagged valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_exu_aluout <= '0;
      end else if (accept && !eng_start) begin
         o_exu_aluout <= alu_res;
      end else if ((state == ST_CALC) && eng_last && !i_flush) begin
         o_exu_aluout <= eng_result;
      end
   end

endmodule
